image_stream_reader: RTL
========================

// Module: image_stream_reader
// PURPOSE
//  Transmit side of the pixel-stream interface consumed by the 3x3 window buffer.
//  On i_start it latches the image parameters and pulses o_load_param with them.
//  It then reads width*height*transfers words from a 1-cycle-latency memory port.
//  Words go out in row-major pixel order, transfers innermost, on a valid/ready stream.
// PARAMETERS
//  WORD_WIDTH      8     width of each transfer word
//  MAX_IMG_WIDTH   128   max image width in pixels
//  MAX_IMG_HEIGHT  128   max image height in pixels
//  MAX_TRANSFERS   512   max transfers per pixel
//  ADDR_WIDTH      16    memory word-address width
// PORTS
//  i_clk           in   1                        clock
//  i_reset_n       in   1                        reset, synchronous, active-low
//  i_start         in   1                        start one image; sampled only in IDLE
//  i_pad           in   1                        pad enable, forwarded
//  i_pad_val       in   WORD_WIDTH               pad value, forwarded
//  i_width         in   $clog2(MAX_IMG_WIDTH)+1  image width (>=3)
//  i_height        in   $clog2(MAX_IMG_HEIGHT)+1 image height (>=3)
//  i_transfers     in   $clog2(MAX_TRANSFERS)+1  transfers per pixel (>=1)
//  i_base_addr     in   ADDR_WIDTH               address of first word
//  o_busy          out  1                        high in any state except IDLE
//  o_done          out  1                        1-cycle pulse after the last word is accepted
//  o_mem_rd_en     out  1                        memory read strobe
//  o_mem_addr      out  ADDR_WIDTH               memory read address
//  i_mem_rd_data   in   WORD_WIDTH               read data, valid the cycle after o_mem_rd_en
//  o_load_param    out  1                        1-cycle pulse; the o_pad..o_transfers outputs are valid while it is high
//  o_pad, o_pad_val, o_width, o_height, o_transfers   out   latched parameter copies
//  o_valid         out  1                        stream word valid
//  o_data          out  WORD_WIDTH               stream word
//  i_ready         in   1                        sink ready; tie high for the window buffer
//  o_last          out  1                        high with the final word of the image
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO flushed, in-flight read discarded.
//   - Also applies mid-stream; the next i_start restarts from i_base_addr.
//  FSM: IDLE -(i_start)-> LOAD -(1 cycle)-> STREAM -(last word accepted)-> DONE -(1 cycle)-> IDLE.
//  i_start while busy is ignored.
//   - Input parameter changes after the start cycle do not affect the run in progress.
//  LOAD: o_load_param=1 for exactly one cycle, with the latched parameters driven.
//   - total = width*height*transfers; its counter is sized $clog2(MAX_IMG_WIDTH*MAX_IMG_HEIGHT*MAX_TRANSFERS)+1.
//  STREAM reads:
//   - o_mem_addr = base + issued count, modulo 2^ADDR_WIDTH (wraps 0xFFFF->0x0000).
//   - First read is issued in the first STREAM cycle.
//  Read data is captured into a 2-entry FIFO.
//   - Issue a read only if fifo_count + inflight - (o_valid & i_ready) < 2 and issued < total.
//   - The FIFO therefore never overflows and no read is ever dropped.
//  Stream handshake:
//   - o_valid = FIFO not empty. A word transfers when o_valid & i_ready.
//   - While stalled, o_valid and o_data are held stable.
//   - With i_ready=1 throughout: the first o_valid comes 2 cycles after o_load_param, then one word/cycle with no gaps.
//  o_last is high only with word index total-1.
//   - After that word transfers, go to DONE: o_done=1 for one cycle with o_busy=1, then IDLE with o_busy=0.
//  Simultaneous FIFO push and pop in the same cycle leaves the count unchanged.
//  Memory: o_mem_rd_en=0 outside STREAM.
//  Parameter outputs: hold their values between runs.
// TESTING
//  1. w=3,h=3,t=1, base=0x0100, mem[a]=a[7:0], i_ready=1 -> o_load_param one cycle, then o_data 0x00..0x08 on consecutive cycles; o_last on 0x08; o_done next cycle.
//  2. w=4,h=3,t=2, base=0x0100 -> 24 words, addresses 0x0100..0x0117 each read once, o_last on word 23 (0x17).
//  3. Same as (1) with i_ready pattern 1,0,1,0 and a 5-cycle low -> o_data stable while stalled; exactly 9 words in order; never more than 2 stored+in-flight.
//  4. Pulse i_start mid-run with w=5 on inputs -> ignored; run completes with 9 words; o_width stays 3.
//  5. Deassert i_reset_n after 5 words accepted -> next cycle all outputs 0; new i_start replays full sequence from base.
//  6. base=0xFFFE, w=h=3,t=1 -> addresses 0xFFFE,0xFFFF,0x0000..0x0006; 9 words, o_last on 9th.

Source files
------------

// File: rtl/image_stream_reader_if.sv
// ============================================================================
// Module   : image_stream_reader_if
// Purpose  : Valid/ready pixel-word stream between the reader and its sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface image_stream_reader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  valid;
  logic [WORD_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

`default_nettype wire

// File: rtl/image_stream_reader.sv
// ============================================================================
// Module   : image_stream_reader
// Purpose  : Reads width*height*transfers words from memory and streams them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_stream_reader #(
  parameter int WORD_WIDTH     = 8,
  parameter int MAX_IMG_WIDTH  = 128,
  parameter int MAX_IMG_HEIGHT = 128,
  parameter int MAX_TRANSFERS  = 512,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic                             i_pad,
  input  logic [WORD_WIDTH-1:0]            i_pad_val,
  input  logic [$clog2(MAX_IMG_WIDTH):0]   i_width,
  input  logic [$clog2(MAX_IMG_HEIGHT):0]  i_height,
  input  logic [$clog2(MAX_TRANSFERS):0]   i_transfers,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  input  logic [WORD_WIDTH-1:0]            i_mem_rd_data,
  output logic                             o_load_param,
  output logic                             o_pad,
  output logic [WORD_WIDTH-1:0]            o_pad_val,
  output logic [$clog2(MAX_IMG_WIDTH):0]   o_width,
  output logic [$clog2(MAX_IMG_HEIGHT):0]  o_height,
  output logic [$clog2(MAX_TRANSFERS):0]   o_transfers,
  image_stream_reader_if.master            strm
);

  localparam int TOT_W = $clog2(MAX_IMG_WIDTH * MAX_IMG_HEIGHT * MAX_TRANSFERS) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TOT_W-1:0]      total;
  logic [TOT_W-1:0]      issued;
  logic [TOT_W-1:0]      accepted;
  logic [ADDR_WIDTH-1:0] base_addr;

  logic [WORD_WIDTH-1:0] fifo_mem [2];
  logic [1:0]            fifo_count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  inflight;

  logic                  start_accept;
  logic                  issue;
  logic                  valid;
  logic                  pop;
  logic                  last_word;
  logic [1:0]            occupancy;
  logic [WORD_WIDTH-1:0] head;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // The word returning from memory this cycle counts as a FIFO entry, so an
  // empty store falls through to i_mem_rd_data and a word appears with no
  // extra register stage.
  always_comb begin
    state_nxt    = state;
    start_accept = 1'b0;
    issue        = 1'b0;
    valid        = (fifo_count != 2'd0) || inflight;
    pop          = valid && strm.ready;
    occupancy    = fifo_count + {1'b0, inflight} - {1'b0, pop};
    last_word    = valid && (accepted == total - TOT_W'(1));
    o_busy       = (state != IDLE);
    o_done       = (state == DONE);
    o_load_param = (state == LOAD);
    case (state)
      IDLE: begin
        if (i_start) begin
          start_accept = 1'b1;
          state_nxt    = LOAD;
        end
      end
      LOAD: state_nxt = STREAM;
      STREAM: begin
        issue = (issued < total) && (occupancy < 2'd2);
        if (pop && last_word) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pad       <= 1'b0;
      o_pad_val   <= '0;
      o_width     <= '0;
      o_height    <= '0;
      o_transfers <= '0;
      base_addr   <= '0;
      total       <= '0;
      issued      <= '0;
      accepted    <= '0;
      inflight    <= 1'b0;
      fifo_count  <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      if (start_accept) begin
        o_pad       <= i_pad;
        o_pad_val   <= i_pad_val;
        o_width     <= i_width;
        o_height    <= i_height;
        o_transfers <= i_transfers;
        base_addr   <= i_base_addr;
        issued      <= '0;
        accepted    <= '0;
      end
      if (state == LOAD)
        total <= TOT_W'(o_width) * TOT_W'(o_height) * TOT_W'(o_transfers);
      if (issue) issued <= issued + TOT_W'(1);
      inflight <= issue;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        accepted <= accepted + TOT_W'(1);
      end
      fifo_count <= occupancy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (inflight) fifo_mem[wr_ptr] <= i_mem_rd_data;
  end

  assign head        = (fifo_count == 2'd0) ? i_mem_rd_data : fifo_mem[rd_ptr];
  assign o_mem_rd_en = issue;
  assign o_mem_addr  = issue ? (base_addr + ADDR_WIDTH'(issued)) : '0;
  assign strm.valid  = valid;
  assign strm.data   = valid ? head : '0;
  assign strm.last   = last_word;

endmodule

`default_nettype wire
